// File: rtl/dram_sequencer.sv
// dram_sequencer: DRAM timing sequencer for a Zorro II FastRAM card.
// Turns a qualified access request into RAS/CAS/MADDR/MEMWn sequences and
// schedules CAS-before-RAS refresh from a saturating debt counter.
//
// Ports:
//   CLK        in   bus clock, all state on the rising edge
//   RESET      in   asynchronous, active-high reset
//   REQ        in   access request, held until the bus cycle ends
//   BANK[1:0]  in   bank select (01->RASn[0], 10->[1], 11->[2], 00->[3])
//   ROW[9:0]   in   row address
//   COL[9:0]   in   column address
//   RWn        in   1 = read, 0 = write
//   UDSn/LDSn  in   active-low byte strobes
//   RASn[3:0]  out  per-bank active-low RAS
//   UCASn/LCASn out active-low CAS per byte lane
//   MEMWn      out  DRAM write enable, active-low
//   MADDR[9:0] out  multiplexed DRAM address
//   ACK        out  data valid / write accepted
//   REF_BUSY   out  high while a refresh sequence owns the array
module dram_sequencer #(
    parameter int unsigned REFRESH_INTERVAL = 108,
    parameter int unsigned PEND_MAX         = 7
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ,
    input  logic [1:0] BANK,
    input  logic [9:0] ROW,
    input  logic [9:0] COL,
    input  logic       RWn,
    input  logic       UDSn,
    input  logic       LDSn,
    output logic [3:0] RASn,
    output logic       UCASn,
    output logic       LCASn,
    output logic       MEMWn,
    output logic [9:0] MADDR,
    output logic       ACK,
    output logic       REF_BUSY
);

    localparam int unsigned IntW = $clog2(REFRESH_INTERVAL);
    localparam logic [IntW-1:0] IntReload = IntW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0] PendMax = 3'(PEND_MAX);

    typedef enum logic [3:0] {
        StIdle, StAccRas, StAccCol, StAccCas, StPrech,
        StRefCas, StRefRas, StRefHold, StRefPre
    } state_e;

    state_e          state_q, state_d;
    logic [IntW-1:0] interval_q, interval_d;
    logic [2:0]      pending_q, pending_d;
    logic [1:0]      bank_q, bank_d;
    logic [9:0]      col_q, col_d;
    logic            rwn_q, rwn_d;
    logic [3:0]      rasn_q, rasn_d;
    logic            ucasn_q, ucasn_d;
    logic            lcasn_q, lcasn_d;
    logic            memwn_q, memwn_d;
    logic [9:0]      maddr_q, maddr_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            tick, ref_done;
    logic [3:0]      bank_ras;

    // Refresh debt: a tick and the REF_PRE retire in the same cycle cancel out.
    always_comb begin
        tick       = (interval_q == '0);
        ref_done   = (state_q == StRefPre);
        interval_d = tick ? IntReload : interval_q - 1'b1;
        pending_d  = pending_q;
        if (tick && !ref_done) begin
            if (pending_q != PendMax) pending_d = pending_q + 3'd1;
        end else if (ref_done && !tick) begin
            if (pending_q != 3'd0) pending_d = pending_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        col_d   = col_q;
        rwn_d   = rwn_q;
        unique case (state_q)
            StIdle: begin
                // Saturated debt outranks a pending access.
                if (pending_q == PendMax) begin
                    state_d = StRefCas;
                end else if (REQ) begin
                    state_d = StAccRas;
                    bank_d  = BANK;
                    col_d   = COL;
                    rwn_d   = RWn;
                end else if (pending_q != 3'd0) begin
                    state_d = StRefCas;
                end
            end
            StAccRas:  state_d = REQ ? StAccCol : StPrech;
            StAccCol:  state_d = REQ ? StAccCas : StPrech;
            StAccCas:  state_d = REQ ? StAccCas : StPrech;
            StPrech:   state_d = StIdle;
            StRefCas:  state_d = StRefRas;
            StRefRas:  state_d = StRefHold;
            StRefHold: state_d = StRefPre;
            StRefPre:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they appear right after the edge.
    always_comb begin
        bank_ras = ~(4'b0001 << (bank_d - 2'd1));
        rasn_d   = 4'hF;
        ucasn_d  = 1'b1;
        lcasn_d  = 1'b1;
        memwn_d  = 1'b1;
        maddr_d  = maddr_q;
        ack_d    = 1'b0;
        busy_d   = 1'b0;
        unique case (state_d)
            StIdle:   maddr_d = ROW;
            StAccRas: begin
                rasn_d  = bank_ras;
                maddr_d = ROW;
            end
            StAccCol: begin
                rasn_d  = bank_ras;
                maddr_d = col_d;
            end
            StAccCas: begin
                rasn_d  = bank_ras;
                maddr_d = col_d;
                ack_d   = 1'b1;
                memwn_d = rwn_d;
                // Each lane latches low once its strobe is seen during the access.
                if (state_q == StAccCas) begin
                    ucasn_d = ucasn_q & UDSn;
                    lcasn_d = lcasn_q & LDSn;
                end else begin
                    ucasn_d = UDSn;
                    lcasn_d = LDSn;
                end
            end
            StPrech: ;
            StRefCas: begin
                ucasn_d = 1'b0;
                lcasn_d = 1'b0;
                busy_d  = 1'b1;
            end
            StRefRas, StRefHold: begin
                rasn_d  = 4'h0;
                ucasn_d = 1'b0;
                lcasn_d = 1'b0;
                busy_d  = 1'b1;
            end
            StRefPre: busy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            interval_q <= IntReload;
            pending_q  <= 3'd0;
            bank_q     <= 2'd0;
            col_q      <= 10'd0;
            rwn_q      <= 1'b1;
            rasn_q     <= 4'hF;
            ucasn_q    <= 1'b1;
            lcasn_q    <= 1'b1;
            memwn_q    <= 1'b1;
            maddr_q    <= 10'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            pending_q  <= pending_d;
            bank_q     <= bank_d;
            col_q      <= col_d;
            rwn_q      <= rwn_d;
            rasn_q     <= rasn_d;
            ucasn_q    <= ucasn_d;
            lcasn_q    <= lcasn_d;
            memwn_q    <= memwn_d;
            maddr_q    <= maddr_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign RASn     = rasn_q;
    assign UCASn    = ucasn_q;
    assign LCASn    = lcasn_q;
    assign MEMWn    = memwn_q;
    assign MADDR    = maddr_q;
    assign ACK      = ack_q;
    assign REF_BUSY = busy_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// Directed testbench for dram_sequencer: access timing, late write strobes,
// abort, asynchronous reset, idle refresh, refresh/access collision and
// refresh-debt saturation.
module tb_dram_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ;
    logic [1:0] BANK;
    logic [9:0] ROW;
    logic [9:0] COL;
    logic       RWn;
    logic       UDSn;
    logic       LDSn;
    logic [3:0] RASn;
    logic       UCASn;
    logic       LCASn;
    logic       MEMWn;
    logic [9:0] MADDR;
    logic       ACK;
    logic       REF_BUSY;

    int n_pass  = 0;
    int n_total = 0;
    int bad;

    dram_sequencer #(
        .REFRESH_INTERVAL(108),
        .PEND_MAX        (7)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ     (REQ),
        .BANK    (BANK),
        .ROW     (ROW),
        .COL     (COL),
        .RWn     (RWn),
        .UDSn    (UDSn),
        .LDSn    (LDSn),
        .RASn    (RASn),
        .UCASn   (UCASn),
        .LCASn   (LCASn),
        .MEMWn   (MEMWn),
        .MADDR   (MADDR),
        .ACK     (ACK),
        .REF_BUSY(REF_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One rising edge, then settle; inputs changed here are sampled next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        REQ   = 1'b0;
        BANK  = 2'd0;
        ROW   = 10'd0;
        COL   = 10'd0;
        RWn   = 1'b1;
        UDSn  = 1'b1;
        LDSn  = 1'b1;
        do_reset();

        chk("rst_rasn", 16'(RASn), 16'hF);
        chk("rst_ucas", 16'(UCASn), 16'h1);
        chk("rst_lcas", 16'(LCASn), 16'h1);
        chk("rst_memw", 16'(MEMWn), 16'h1);
        chk("rst_maddr", 16'(MADDR), 16'h0);
        chk("rst_ack", 16'(ACK), 16'h0);
        chk("rst_busy", 16'(REF_BUSY), 16'h0);

        // Read, bank 10 -> RASn[1]
        REQ = 1'b1; BANK = 2'b10; ROW = 10'h155; COL = 10'h2AA; RWn = 1'b1;
        UDSn = 1'b0; LDSn = 1'b0;
        tick();
        chk("rd1_rasn", 16'(RASn), 16'hD);
        chk("rd1_maddr", 16'(MADDR), 16'h155);
        chk("rd1_ucas", 16'(UCASn), 16'h1);
        chk("rd1_ack", 16'(ACK), 16'h0);
        tick();
        chk("rd2_maddr", 16'(MADDR), 16'h2AA);
        chk("rd2_rasn", 16'(RASn), 16'hD);
        chk("rd2_ack", 16'(ACK), 16'h0);
        tick();
        chk("rd3_ucas", 16'(UCASn), 16'h0);
        chk("rd3_lcas", 16'(LCASn), 16'h0);
        chk("rd3_ack", 16'(ACK), 16'h1);
        chk("rd3_memw", 16'(MEMWn), 16'h1);
        REQ = 1'b0;
        tick();
        chk("rd4_rasn", 16'(RASn), 16'hF);
        chk("rd4_ucas", 16'(UCASn), 16'h1);
        chk("rd4_lcas", 16'(LCASn), 16'h1);
        chk("rd4_ack", 16'(ACK), 16'h0);
        ROW = 10'h0AB;
        tick();
        tick();
        chk("idle_maddr_row", 16'(MADDR), 16'h0AB);

        // Late write, bank 00 -> RASn[3], only the low lane strobes late
        REQ = 1'b1; BANK = 2'b00; COL = 10'h3C3; RWn = 1'b0; UDSn = 1'b1; LDSn = 1'b1;
        tick();
        chk("wr1_rasn", 16'(RASn), 16'h7);
        tick();
        chk("wr2_maddr", 16'(MADDR), 16'h3C3);
        tick();
        chk("wr3_memw", 16'(MEMWn), 16'h0);
        chk("wr3_ack", 16'(ACK), 16'h1);
        chk("wr3_lcas", 16'(LCASn), 16'h1);
        chk("wr3_ucas", 16'(UCASn), 16'h1);
        LDSn = 1'b0;
        tick();
        chk("wr4_lcas", 16'(LCASn), 16'h0);
        chk("wr4_ucas", 16'(UCASn), 16'h1);
        LDSn = 1'b1;
        tick();
        chk("wr5_lcas_held", 16'(LCASn), 16'h0);
        REQ = 1'b0; RWn = 1'b1;
        tick();
        chk("wr6_lcas", 16'(LCASn), 16'h1);
        chk("wr6_memw", 16'(MEMWn), 16'h1);
        chk("wr6_rasn", 16'(RASn), 16'hF);
        tick();

        // Abort in ACC_COL
        REQ = 1'b1; BANK = 2'b01; UDSn = 1'b0; LDSn = 1'b0;
        tick();
        chk("ab1_rasn", 16'(RASn), 16'hE);
        tick();
        chk("ab2_ack", 16'(ACK), 16'h0);
        REQ = 1'b0;
        tick();
        chk("ab3_rasn", 16'(RASn), 16'hF);
        chk("ab3_ack", 16'(ACK), 16'h0);
        chk("ab3_ucas", 16'(UCASn), 16'h1);
        tick();
        chk("ab4_ack", 16'(ACK), 16'h0);

        // Asynchronous reset during ACC_CAS
        REQ = 1'b1; BANK = 2'b11;
        tick();
        tick();
        tick();
        chk("ar_ack_before", 16'(ACK), 16'h1);
        chk("ar_rasn_before", 16'(RASn), 16'hB);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_rasn", 16'(RASn), 16'hF);
        chk("ar_ucas", 16'(UCASn), 16'h1);
        chk("ar_lcas", 16'(LCASn), 16'h1);
        chk("ar_ack", 16'(ACK), 16'h0);
        chk("ar_maddr", 16'(MADDR), 16'h0);
        REQ = 1'b0;
        tick();
        RESET = 1'b0;

        // Idle refresh: debt appears at edge 108, REF_CAS entered at edge 109
        bad = 0;
        for (int i = 1; i <= 108; i++) begin
            tick();
            if (UCASn !== 1'b1 || REF_BUSY !== 1'b0) bad++;
        end
        chk("rf_none_early", 16'(bad), 16'h0);
        tick();
        chk("rf1_ucas", 16'(UCASn), 16'h0);
        chk("rf1_lcas", 16'(LCASn), 16'h0);
        chk("rf1_rasn", 16'(RASn), 16'hF);
        chk("rf1_busy", 16'(REF_BUSY), 16'h1);
        chk("rf1_memw", 16'(MEMWn), 16'h1);
        tick();
        chk("rf2_rasn", 16'(RASn), 16'h0);
        chk("rf2_ucas", 16'(UCASn), 16'h0);
        tick();
        chk("rf3_rasn", 16'(RASn), 16'h0);
        chk("rf3_busy", 16'(REF_BUSY), 16'h1);
        tick();
        chk("rf4_rasn", 16'(RASn), 16'hF);
        chk("rf4_ucas", 16'(UCASn), 16'h1);
        chk("rf4_busy", 16'(REF_BUSY), 16'h1);
        tick();
        chk("rf5_busy", 16'(REF_BUSY), 16'h0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (REF_BUSY !== 1'b0) bad++;
        end
        chk("rf_debt_cleared", 16'(bad), 16'h0);

        // Collision: REQ rises as REF_CAS is entered
        do_reset();
        for (int i = 1; i <= 109; i++) tick();
        chk("col_refcas", 16'(REF_BUSY), 16'h1);
        REQ = 1'b1; BANK = 2'b10; RWn = 1'b1; UDSn = 1'b0; LDSn = 1'b0;
        bad = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (ACK !== 1'b0) bad++;
            if (i == 5) chk("col_ras_after_pre", 16'(RASn), 16'hD);
        end
        chk("col_no_early_ack", 16'(bad), 16'h0);
        tick();
        chk("col_ack_edge7", 16'(ACK), 16'h1);
        REQ = 1'b0;
        tick();
        tick();

        // Saturation: hold REQ for 8 intervals, debt saturates at 7
        do_reset();
        REQ = 1'b1; BANK = 2'b01;
        bad = 0;
        for (int i = 1; i <= 864; i++) begin
            tick();
            if (REF_BUSY !== 1'b0) bad++;
            if (i >= 3 && ACK !== 1'b1) bad++;
        end
        chk("sat_hold", 16'(bad), 16'h0);
        REQ = 1'b0;
        tick();
        chk("sat_prech", 16'(RASn), 16'hF);
        REQ = 1'b1;
        tick();
        chk("sat_idle", 16'(RASn), 16'hF);
        tick();
        chk("sat_urgent_busy", 16'(REF_BUSY), 16'h1);
        chk("sat_urgent_rasn", 16'(RASn), 16'hF);
        tick();
        tick();
        tick();
        tick();
        chk("sat_idle2", 16'(REF_BUSY), 16'h0);
        tick();
        chk("sat_req_wins", 16'(RASn), 16'hE);
        chk("sat_req_busy", 16'(REF_BUSY), 16'h0);
        REQ = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
